// File: rtl/fp_pkg.sv
// Shared floating-point pixel definitions: default field widths, word-width
// derivation and the fp16 pixel layout.
package fp_pkg;

  localparam int unsigned DEF_EXP_WIDTH  = 5;
  localparam int unsigned DEF_FRAC_WIDTH = 10;
  localparam int unsigned COORD_WIDTH    = 16;

  function automatic int unsigned fp_width(input int unsigned exp_w,
                                           input int unsigned frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  localparam int unsigned FP16_WIDTH = fp_width(DEF_EXP_WIDTH, DEF_FRAC_WIDTH);

  typedef struct packed {
    logic                      sign;
    logic [DEF_EXP_WIDTH-1:0]  exp;
    logic [DEF_FRAC_WIDTH-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/line_buffer_fp.sv
// One image row of pixel storage: single-port RAM, asynchronous read of the
// old word and write of the new word at the same address in one cycle.
module line_buffer_fp #(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned DEPTH      = 640,
  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_c_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_c_o = mem_q[addr_i];

  // Storage is intentionally not reset; stale rows are never windowed.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wr_data_i;
  end

endmodule

// File: rtl/window_generator_fp.sv
// Sliding WINDOW_HEIGHT x WINDOW_WIDTH window over a raster-order fp pixel
// stream, emitting only windows fully inside the current frame.
module window_generator_fp
  import fp_pkg::*;
#(
  parameter  int unsigned EXP_WIDTH     = DEF_EXP_WIDTH,
  parameter  int unsigned FRAC_WIDTH    = DEF_FRAC_WIDTH,
  parameter  int unsigned WINDOW_WIDTH  = 3,
  parameter  int unsigned WINDOW_HEIGHT = 3,
  parameter  int unsigned IMAGE_WIDTH   = 640,
  parameter  int unsigned IMAGE_HEIGHT  = 480,
  localparam int unsigned FP_WIDTH_REG  = fp_width(EXP_WIDTH, FRAC_WIDTH)
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_i,
  input  logic [FP_WIDTH_REG-1:0]                                   data_i,
  input  logic                                                      valid_i,
  input  logic                                                      sof_i,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
  output logic [15:0]                                               col_o,
  output logic [15:0]                                               row_o,
  output logic                                                      valid_o
);

  localparam int unsigned CW  = COORD_WIDTH;
  localparam int unsigned AW  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned NLB = WINDOW_HEIGHT - 1;

  typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win_t;

  logic [CW-1:0]           col_q, col_d, row_q, row_d;
  logic [CW-1:0]           pix_col, pix_row;
  logic [CW-1:0]           col_out_q, col_out_d, row_out_q, row_out_d;
  logic                    valid_q, valid_d;
  win_t                    window_q, window_d;
  logic [FP_WIDTH_REG-1:0] lb_rd [NLB];

  // Line buffer 0 holds the previous row; each buffer's old word cascades down.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    logic [FP_WIDTH_REG-1:0] wr_data;
    if (k == 0) begin : g_first
      assign wr_data = data_i;
    end else begin : g_chain
      assign wr_data = lb_rd[k-1];
    end
    line_buffer_fp #(
      .DATA_WIDTH(FP_WIDTH_REG),
      .DEPTH     (IMAGE_WIDTH)
    ) u_lb (
      .clk_i      (clk_i),
      .we_i       (valid_i),
      .addr_i     (AW'(pix_col)),
      .wr_data_i  (wr_data),
      .rd_data_c_o(lb_rd[k])
    );
  end

  // Position of the current pixel (sof forces origin), counter advance, window shift.
  always_comb begin
    pix_col   = sof_i ? '0 : col_q;
    pix_row   = sof_i ? '0 : row_q;
    col_d     = col_q;
    row_d     = row_q;
    valid_d   = 1'b0;
    col_out_d = col_out_q;
    row_out_d = row_out_q;
    window_d  = window_q;
    if (valid_i) begin
      if (pix_col == CW'(IMAGE_WIDTH - 1)) begin
        col_d = '0;
        row_d = (pix_row == CW'(IMAGE_HEIGHT - 1)) ? '0 : pix_row + CW'(1);
      end else begin
        col_d = pix_col + CW'(1);
        row_d = pix_row;
      end
      valid_d = (pix_col >= CW'(WINDOW_WIDTH - 1)) &&
                (pix_row >= CW'(WINDOW_HEIGHT - 1));
      if (valid_d) begin
        col_out_d = pix_col - CW'(WINDOW_WIDTH / 2);
        row_out_d = pix_row - CW'(WINDOW_HEIGHT / 2);
      end
      for (int r = 0; r < WINDOW_HEIGHT; r++) begin
        for (int c = 0; c < WINDOW_WIDTH - 1; c++) begin
          window_d[r][c] = window_q[r][c+1];
        end
      end
      for (int r = 0; r < WINDOW_HEIGHT - 1; r++) begin
        window_d[r][WINDOW_WIDTH-1] = lb_rd[NLB-1-r];
      end
      window_d[WINDOW_HEIGHT-1][WINDOW_WIDTH-1] = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      col_q     <= '0;
      row_q     <= '0;
      col_out_q <= '0;
      row_out_q <= '0;
      valid_q   <= 1'b0;
      window_q  <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      col_out_q <= col_out_d;
      row_out_q <= row_out_d;
      valid_q   <= valid_d;
      window_q  <= window_d;
    end
  end

  assign window_o = window_q;
  assign col_o    = col_out_q;
  assign row_o    = row_out_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_window_generator_fp.sv
// Self-checking bench: 3x3 and 5x5 generators on an 8x6 frame against a
// frame-image reference model.
module tb_window_generator_fp;
  import fp_pkg::*;

  localparam int IW = 8;
  localparam int IH = 6;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b0;
  logic [15:0]              data_i = '0;
  logic                     valid_i = 1'b0;
  logic                     sof_i = 1'b0;
  logic [2:0][2:0][15:0]    window3;
  logic [4:0][4:0][15:0]    window5;
  logic [15:0]              col3, row3, col5, row5;
  logic                     valid3, valid5;

  int tests = 0;
  int fails = 0;
  int win_cnt3, win_cnt5;
  int mc = 0, mr = 0;
  logic [15:0] img [IH][IW];
  logic [2:0][2:0][15:0] last3;
  logic [4:0][4:0][15:0] last5;
  int lastc3, lastr3, lastc5, lastr5;
  bit hold3 = 0, hold5 = 0;

  always #5 clk_i = ~clk_i;

  window_generator_fp #(.WINDOW_WIDTH(3), .WINDOW_HEIGHT(3),
                        .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .sof_i(sof_i), .window_o(window3), .col_o(col3), .row_o(row3),
    .valid_o(valid3));

  window_generator_fp #(.WINDOW_WIDTH(5), .WINDOW_HEIGHT(5),
                        .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) u_dut5 (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .sof_i(sof_i), .window_o(window5), .col_o(col5), .row_o(row5),
    .valid_o(valid5));

  // Non-negative integer (< 2048) to half-precision bit pattern.
  function automatic logic [15:0] fp16(input int n);
    fp16_t f;
    int    p;
    f = '0;
    if (n > 0) begin
      p = 0;
      for (int i = 0; i < 12; i++) if (n >= (1 << i)) p = i;
      f.exp  = 5'(p + 15);
      f.frac = 10'((n << (10 - p)) & 'h3FF);
    end
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [399:0] act, input logic [399:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of input and check both DUTs against the frame model.
  task automatic step(input logic v, input logic s, input logic [15:0] d);
    logic [2:0][2:0][15:0] e3;
    logic [4:0][4:0][15:0] e5;
    bit ev3, ev5;
    valid_i = v; sof_i = s; data_i = d;
    @(posedge clk_i); #1;
    win_cnt3 += int'(valid3);
    win_cnt5 += int'(valid5);
    if (v) begin
      if (s) begin mc = 0; mr = 0; end
      img[mr][mc] = d;
      ev3 = (mc >= 2) && (mr >= 2);
      ev5 = (mc >= 4) && (mr >= 4);
      chk("valid3", 32'(valid3), 32'(ev3));
      chk("valid5", 32'(valid5), 32'(ev5));
      if (ev3) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) e3[r][c] = img[mr-2+r][mc-2+c];
        chk_w("window3", 400'(window3), 400'(e3));
        chk("col3", 32'(col3), 32'(mc - 1));
        chk("row3", 32'(row3), 32'(mr - 1));
        last3 = e3; lastc3 = mc - 1; lastr3 = mr - 1;
      end
      if (ev5) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) e5[r][c] = img[mr-4+r][mc-4+c];
        chk_w("window5", 400'(window5), 400'(e5));
        chk("col5", 32'(col5), 32'(mc - 2));
        chk("row5", 32'(row5), 32'(mr - 2));
        last5 = e5; lastc5 = mc - 2; lastr5 = mr - 2;
      end
      hold3 = ev3;
      hold5 = ev5;
      if (mc == IW - 1) begin
        mc = 0;
        mr = (mr == IH - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end else begin
      chk("idle_valid3", 32'(valid3), 0);
      chk("idle_valid5", 32'(valid5), 0);
      if (hold3) begin
        chk_w("hold_window3", 400'(window3), 400'(last3));
        chk("hold_col3", 32'(col3), 32'(lastc3));
        chk("hold_row3", 32'(row3), 32'(lastr3));
      end
      if (hold5) chk_w("hold_window5", 400'(window5), 400'(last5));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid3"}, 32'(valid3), 0);
    chk({tag, "_col3"}, 32'(col3), 0);
    chk({tag, "_row3"}, 32'(row3), 0);
    chk_w({tag, "_window3"}, 400'(window3), '0);
    chk({tag, "_valid5"}, 32'(valid5), 0);
    chk_w({tag, "_window5"}, 400'(window5), '0);
  endtask

  typedef struct {
    int k;
    int col;
    int row;
    int tl;
    int br;
    bit is5;
  } vec_t;

  vec_t tbl [6];
  int   first_valid;
  logic [15:0] first_col, first_row;

  initial begin
    tbl[0] = '{18, 1, 1, 0, 18, 1'b0};
    tbl[1] = '{23, 6, 1, 5, 23, 1'b0};
    tbl[2] = '{26, 1, 2, 8, 26, 1'b0};
    tbl[3] = '{47, 6, 4, 29, 47, 1'b0};
    tbl[4] = '{36, 2, 2, 0, 36, 1'b1};
    tbl[5] = '{47, 5, 3, 11, 47, 1'b1};

    #2 chk_zero("reset");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Continuous frame of fp16(index) with spot checks from the table.
    win_cnt3 = 0; win_cnt5 = 0;
    for (int k = 0; k < IW * IH; k++) begin
      step(1'b1, k == 0, fp16(k));
      for (int i = 0; i < 6; i++) begin
        if (tbl[i].k == k) begin
          if (tbl[i].is5) begin
            chk("tbl_col5", 32'(col5), 32'(tbl[i].col));
            chk("tbl_row5", 32'(row5), 32'(tbl[i].row));
            chk("tbl_tl5", 32'(window5[0][0]), 32'(fp16(tbl[i].tl)));
            chk("tbl_br5", 32'(window5[4][4]), 32'(fp16(tbl[i].br)));
          end else begin
            chk("tbl_col3", 32'(col3), 32'(tbl[i].col));
            chk("tbl_row3", 32'(row3), 32'(tbl[i].row));
            chk("tbl_tl3", 32'(window3[0][0]), 32'(fp16(tbl[i].tl)));
            chk("tbl_br3", 32'(window3[2][2]), 32'(fp16(tbl[i].br)));
          end
        end
      end
    end
    chk("frame_windows3", 32'(win_cnt3), 24);
    chk("frame_windows5", 32'(win_cnt5), 8);

    // Same frame with valid_i toggling every cycle.
    win_cnt3 = 0; win_cnt5 = 0;
    for (int k = 0; k < IW * IH; k++) begin
      step(1'b1, k == 0, fp16(k));
      step(1'b0, 1'b0, 16'($urandom));
    end
    chk("toggle_windows3", 32'(win_cnt3), 24);
    chk("toggle_windows5", 32'(win_cnt5), 8);

    // Resync with sof on pixel 20 of a frame.
    for (int k = 0; k < 20; k++) step(1'b1, k == 0, fp16(k + 50));
    first_valid = -1; first_col = '0; first_row = '0;
    for (int j = 0; j < 25; j++) begin
      step(1'b1, j == 0, fp16(j + 200));
      if (valid3 && first_valid < 0) begin
        first_valid = j; first_col = col3; first_row = row3;
      end
    end
    chk("sof_first_valid", 32'(first_valid), 18);
    chk("sof_first_col", 32'(first_col), 1);
    chk("sof_first_row", 32'(first_row), 1);

    // One-cycle reset at pixel 30, then a full frame without sof.
    for (int k = 0; k < 30; k++) step(1'b1, k == 0, fp16(k + 300));
    valid_i = 1'b0; sof_i = 1'b0;
    rst_i = 1'b0;
    #2 chk_zero("midrst");
    @(posedge clk_i); #1;
    chk_zero("midrst_hold");
    rst_i = 1'b1;
    mc = 0; mr = 0; hold3 = 0; hold5 = 0;
    win_cnt3 = 0; win_cnt5 = 0;
    for (int k = 0; k < IW * IH; k++) step(1'b1, 1'b0, fp16(k + 1));
    chk("postrst_windows3", 32'(win_cnt3), 24);
    chk("postrst_windows5", 32'(win_cnt5), 8);

    // Two back-to-back frames with distinct content.
    win_cnt3 = 0; win_cnt5 = 0;
    for (int k = 0; k < IW * IH; k++) step(1'b1, k == 0, fp16(k + 600));
    for (int k = 0; k < IW * IH; k++) begin
      step(1'b1, k == 0, fp16(k));
      if (k == 18) chk("b2b_first_tl3", 32'(window3[0][0]), 32'(fp16(0)));
    end
    chk("b2b_windows3", 32'(win_cnt3), 48);
    chk("b2b_windows5", 32'(win_cnt5), 16);

    // Random traffic: gaps, occasional resync, random data.
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) != 0, ($urandom % 64) == 0, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/window_generator_fp.md
WINDOW_GENERATOR_FP -- requirements
Module: window_generator_fp

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 5, exponent width of pixel word.
REQ-002 SHALL have parameter FRAC_WIDTH, default 10, fraction width; FP_WIDTH_REG = 1+EXP_WIDTH+FRAC_WIDTH.
REQ-003 SHALL have parameters WINDOW_WIDTH, WINDOW_HEIGHT, both default 3, odd only, window size.
REQ-004 SHALL have parameters IMAGE_WIDTH, default 640, and IMAGE_HEIGHT, default 480, frame size in pixels.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  clock, all state on rising edge.
REQ-006 SHALL have rst_i  in  1  asynchronous active-low reset.
REQ-007 SHALL have data_i  in  FP_WIDTH_REG  raster-order pixel, fp format.
REQ-008 SHALL have valid_i  in  1  data_i qualifier; no backpressure.
REQ-009 SHALL have sof_i  in  1  start of frame, sampled only with valid_i.
REQ-010 SHALL have window_o  out  FP_WIDTH_REG x [WINDOW_HEIGHT][WINDOW_WIDTH]  window; [0][0] = top-left (oldest row, oldest column).
REQ-011 SHALL have col_o, row_o  out  16 each  image coordinate of window centre pixel.
REQ-012 SHALL have valid_o  out  1  window_o/col_o/row_o qualifier; drives a convolution stage directly.

Function
REQ-013 SHALL track input position with col/row counters; col increments per accepted pixel, wraps at IMAGE_WIDTH-1 to 0 and increments row; row wraps at IMAGE_HEIGHT-1 to 0.
REQ-014 SHALL, on valid_i && sof_i, treat the pixel as col=0,row=0 regardless of counter state (resync); line-buffer contents are not cleared.
REQ-015 SHALL hold WINDOW_HEIGHT-1 line buffers of IMAGE_WIDTH words, addressed by col; on each accepted pixel, buffer k read value shifts into buffer k+1 write, data_i writes buffer 0 (read-before-write, same address).
REQ-016 SHALL keep a WINDOW_HEIGHT x WINDOW_WIDTH shift-register window; on each accepted pixel columns shift left by one and the new rightmost column = {oldest line buffer read, ..., newest line buffer read, data_i} top to bottom.
REQ-017 SHALL assert valid_o exactly 1 cycle after an accepted pixel whose col >= WINDOW_WIDTH-1 and row >= WINDOW_HEIGHT-1; otherwise valid_o = 0.
REQ-018 SHALL output col_o = col - WINDOW_WIDTH/2, row_o = row - WINDOW_HEIGHT/2 (integer division) of that pixel, registered with valid_o.
REQ-019 SHALL hold window_o/col_o/row_o stable when valid_i = 0 (no bubble shifts).
REQ-020 SHALL produce no windows straddling a row wrap: columns from the previous row never appear in a valid window.
REQ-021 SHALL produce (IMAGE_WIDTH-WINDOW_WIDTH+1)*(IMAGE_HEIGHT-WINDOW_HEIGHT+1) valid windows per full frame; no border padding.
REQ-022 SHALL accept one pixel per cycle sustained, back-to-back frames with no gap.

Reset
REQ-023 SHALL on rst_i low immediately clear col/row counters, valid_o, col_o, row_o, window_o to 0.
REQ-024 SHALL not reset line-buffer RAM; post-reset first valid window contains only post-reset pixels per REQ-017.
REQ-025 SHALL, on reset mid-frame, restart at col=0,row=0 with the first pixel after release.

Structure
REQ-026 SHALL place FP_WIDTH_REG derivation, default EXP_WIDTH/FRAC_WIDTH and fp16 pixel typedef in shared package fp_pkg.
REQ-027 SHALL instantiate sub-module line_buffer_fp (single-port read-before-write RAM, IMAGE_WIDTH deep) once per buffered row.

Verification
REQ-028 SHALL cover: IMAGE 8x6, 3x3, pixels = fp16(index 0..47), continuous -> 24 valid windows; first at col_o=1,row_o=1, window [0][0]=fp16(0), [2][2]=fp16(18).
REQ-029 SHALL cover: same frame with valid_i toggling 1/0 every cycle -> identical window sequence, valid_o only 1 cycle after accepted pixels.
REQ-030 SHALL cover: sof_i at pixel 20 of frame -> counters restart, next valid window 1 cycle after 19th post-sof pixel (col=2,row=2), col_o=1,row_o=1.
REQ-031 SHALL cover: rst_i low 1 cycle at pixel 30 -> outputs 0 asynchronously, next frame produces 24 correct windows.
REQ-032 SHALL cover: two back-to-back frames -> 48 windows, frame 2 first window [0][0]=fp16(0) of frame 2, no row-wrap mixing at col_o=6.
REQ-033 SHALL cover: WINDOW 5x5 on 8x6 -> 8 windows, first col_o=2,row_o=2.
